// File: rtl/lissajous_pkg.sv
// Shared types and helpers for the Lissajous point generator.
// Holds the mode encoding, FSM state constants and the unsigned 8-bit clamp.
package lissajous_pkg;

    typedef enum logic {
        MODE_CIRCLE = 1'b0,
        MODE_XY     = 1'b1
    } mode_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CIRCLE = 2'd1;
    localparam state_t ST_EMIT   = 2'd2;

    function automatic logic [7:0] sat_u8(input logic signed [31:0] v);
        if (v < 0) begin
            return 8'd0;
        end else if (v > 32'sd255) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/sample_decimator.sv
// Keeps one of every DECIMATION enabled strobes; event_o is a one-cycle
// pulse raised combinationally with the strobe that completes the count.
import lissajous_pkg::*;

module sample_decimator #(
    parameter int DECIMATION = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_i,
    input  logic strb_i,
    output logic event_o
);

    localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIMATION - 1);

    logic [CW-1:0] dc_q;
    logic [CW-1:0] dc_d;
    logic          take;

    assign take    = strb_i & enable_i;
    assign event_o = take & (dc_q == LAST);

    always_comb begin
        dc_d = dc_q;
        if (take) begin
            dc_d = (dc_q == LAST) ? '0 : dc_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end

endmodule

// File: rtl/lissajous_point_gen.sv
// Decimated sample pairs become screen points: circle mode goes through the
// external circle unit, XY mode maps L/R straight to a clamped x/y.
import lissajous_pkg::*;

module lissajous_point_gen #(
    parameter int DATA_W          = 16,
    parameter int DECIMATION      = 200,
    parameter int ANGLE_W         = 10,
    parameter int ANGLE_INCREMENT = 8,
    parameter int HUE_STEP        = 1,
    parameter int R_SHIFT         = 4,
    parameter int XY_SHIFT        = 8,
    parameter int X0              = 120,
    parameter int Y0              = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic                     mode_i,
    input  logic                     strb_i,
    input  logic signed [DATA_W-1:0] l_i,
    input  logic signed [DATA_W-1:0] r_i,
    output logic [ANGLE_W-1:0]       cir_angle_o,
    output logic [7:0]               cir_r_o,
    output logic                     cir_req_o,
    input  logic                     cir_ack_i,
    input  logic [7:0]               cir_x_i,
    input  logic [7:0]               cir_y_i,
    output logic [7:0]               pt_x_o,
    output logic [7:0]               pt_y_o,
    output logic [7:0]               pt_h_o,
    output logic                     pt_req_o,
    input  logic                     pt_ack_i,
    output logic [15:0]              drop_cnt_o,
    output logic [1:0]               state_o
);

    localparam int XW = DATA_W + 2;

    logic event_w;

    sample_decimator #(
        .DECIMATION(DECIMATION)
    ) u_dec (
        .clock   (clock),
        .reset   (reset),
        .enable_i(enable_i),
        .strb_i  (strb_i),
        .event_o (event_w)
    );

    // Radius: saturating |L| so the most negative sample does not wrap to itself.
    logic [DATA_W-1:0] abs_l;
    logic [DATA_W-1:0] abs_sh;
    logic [7:0]        radius;

    always_comb begin
        if (l_i == {1'b1, {(DATA_W-1){1'b0}}}) begin
            abs_l = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (l_i[DATA_W-1]) begin
            abs_l = -l_i;
        end else begin
            abs_l = l_i;
        end
        abs_sh = abs_l >> R_SHIFT;
        radius = (abs_sh > DATA_W'(255)) ? 8'hFF : abs_sh[7:0];
    end

    logic signed [XW-1:0] l_ext;
    logic signed [XW-1:0] r_ext;
    logic signed [XW-1:0] x_sum;
    logic signed [XW-1:0] y_sum;
    logic [7:0]           xy_x;
    logic [7:0]           xy_y;

    assign l_ext = XW'(l_i);
    assign r_ext = XW'(r_i);
    assign x_sum = XW'(X0) + (l_ext >>> XY_SHIFT);
    assign y_sum = XW'(Y0) - (r_ext >>> XY_SHIFT);
    assign xy_x  = sat_u8(32'(x_sum));
    assign xy_y  = sat_u8(32'(y_sum));

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [7:0]         hue_q, hue_d;
    logic [15:0]        drop_q, drop_d;
    logic [7:0]         pt_x_q, pt_x_d;
    logic [7:0]         pt_y_q, pt_y_d;
    logic [7:0]         cir_r_q, cir_r_d;

    // Handshake: each req is high for exactly the cycles its state is held;
    // a cycle with req and ack both high completes the transfer and req
    // falls on the next edge. Ack with req low has no effect.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        angle_d = angle_q;
        hue_d   = hue_q;
        drop_d  = drop_q;
        pt_x_d  = pt_x_q;
        pt_y_d  = pt_y_q;
        cir_r_d = cir_r_q;

        case (state_q)
            ST_IDLE: begin
                if (event_w) begin
                    mode_d = mode_t'(mode_i);
                    if (mode_t'(mode_i) == MODE_XY) begin
                        pt_x_d  = xy_x;
                        pt_y_d  = xy_y;
                        state_d = ST_EMIT;
                    end else begin
                        cir_r_d = radius;
                        state_d = ST_CIRCLE;
                    end
                end
            end
            ST_CIRCLE: begin
                if (cir_ack_i) begin
                    pt_x_d  = cir_x_i;
                    pt_y_d  = cir_y_i;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (pt_ack_i) begin
                    hue_d = hue_q + 8'(HUE_STEP);
                    if (mode_q == MODE_CIRCLE) begin
                        angle_d = angle_q + ANGLE_W'(ANGLE_INCREMENT);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (event_w && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CIRCLE;
            angle_q <= '0;
            hue_q   <= '0;
            drop_q  <= '0;
            pt_x_q  <= '0;
            pt_y_q  <= '0;
            cir_r_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            angle_q <= angle_d;
            hue_q   <= hue_d;
            drop_q  <= drop_d;
            pt_x_q  <= pt_x_d;
            pt_y_q  <= pt_y_d;
            cir_r_q <= cir_r_d;
        end
    end

    assign cir_req_o   = (state_q == ST_CIRCLE);
    assign pt_req_o    = (state_q == ST_EMIT);
    assign cir_angle_o = angle_q;
    assign cir_r_o     = cir_r_q;
    assign pt_x_o      = pt_x_q;
    assign pt_y_o      = pt_y_q;
    assign pt_h_o      = hue_q;
    assign drop_cnt_o  = drop_q;
    assign state_o     = state_q;

endmodule
